serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl_pkg.sv | 12 +
 rtl/serial_add_ctrl_cell.sv | 27 ++
 rtl/serial_add_ctrl.sv | 110 +++++++++++
 tb/tb_serial_add_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and default width.
package serial_add_ctrl_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_add_ctrl_cell.sv
// One-bit full adder cell built from two half adders; purely combinational.
module half_adder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module bit_adder_cell (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);
   logic w_s1;
   logic w_c1;
   logic w_c2;

   half_adder u_ha0 (.x(x),    .y(y),   .s(w_s1), .c(w_c1));
   half_adder u_ha1 (.x(w_s1), .y(cin), .s(s),    .c(w_c2));

   assign cout = w_c1 | w_c2;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: sequences one full-adder cell LSB first over WIDTH cycles.
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   logic [WIDTH-1:0] r_sum;
   logic [CW-1:0]    r_cnt;
   logic             r_c;
   logic             r_cout;
   logic             r_busy;
   logic             r_done;
   logic             w_s;
   logic             w_cnext;
   logic             w_last;

   assign w_last = (r_cnt == LAST);

   bit_adder_cell u_cell (
      .x    (r_opa[0]),
      .y    (r_opb[0]),
      .cin  (r_c),
      .s    (w_s),
      .cout (w_cnext)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start)  w_state_nxt = RUN;
         RUN:     if (w_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // busy/done are registered from the next state so they line up with r_state without decode glitches
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt != IDLE);
         r_done <= (w_state_nxt == DONE);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_opa  <= '0;
         r_opb  <= '0;
         r_sum  <= '0;
         r_cnt  <= '0;
         r_c    <= 1'b0;
         r_cout <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_opa  <= a;
                  r_opb  <= b;
                  r_sum  <= '0;
                  r_cnt  <= '0;
                  r_c    <= 1'b0;
                  r_cout <= 1'b0;
               end
            end
            RUN: begin
               r_sum <= {w_s, r_sum[WIDTH-1:1]};
               r_opa <= {1'b0, r_opa[WIDTH-1:1]};
               r_opb <= {1'b0, r_opb[WIDTH-1:1]};
               r_c   <= w_cnext;
               // counter parks at WIDTH-1 on the last bit so it never wraps
               if (w_last) r_cout <= w_cnext;
               else        r_cnt  <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign sum       = r_sum;
   assign carry_out = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=3.
module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8, start3;
   logic [7:0] a8, b8, sum8;
   logic [2:0] a3, b3, sum3;
   logic       busy8, done8, cout8;
   logic       busy3, done3, cout3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .sum(sum8), .carry_out(cout8)
   );

   serial_add_ctrl #(.WIDTH(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
      .busy(busy3), .done(done3), .sum(sum3), .carry_out(cout3)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] result(input bit sel);
      return sel ? {5'd0, cout3, sum3} : {cout8, sum8};
   endfunction

   // One operation; the reference is plain a+b, latency WIDTH edges after the start edge.
   task automatic run_op(input bit sel, input logic [7:0] av, input logic [7:0] bv,
                         input bit pulse_mid, input string tag);
      int         w;
      int         lat;
      int         bcnt;
      logic [8:0] exp;
      logic [8:0] got;
      w   = sel ? 3 : 8;
      exp = sel ? (9'(av[2:0]) + 9'(bv[2:0])) : (9'(av) + 9'(bv));
      @(negedge clk);
      if (sel) begin a3 = av[2:0]; b3 = bv[2:0]; start3 = 1'b1; end
      else     begin a8 = av;      b8 = bv;      start8 = 1'b1; end
      @(posedge clk); #1;
      start3 = 1'b0;
      start8 = 1'b0;
      lat  = -1;
      bcnt = 0;
      got  = '0;
      for (int n = 0; n < 40; n++) begin
         if (!(sel ? busy3 : busy8)) break;
         bcnt++;
         if (sel ? done3 : done8) begin
            lat = n;
            got = result(sel);
         end
         if (!sel && pulse_mid) begin
            start8 = (n == 2 || n == 4);
            a8 = ~a8;
            b8 = b8 + 8'd3;
         end
         @(posedge clk); #1;
      end
      start8 = 1'b0;
      check_eq({tag, ".lat"},  64'(lat),  64'(w));
      check_eq({tag, ".busy"}, 64'(bcnt), 64'(w + 1));
      check_eq({tag, ".res"},  64'(got),  64'(exp));
      check_eq({tag, ".hold"}, 64'(result(sel)), 64'(exp));
      check_eq({tag, ".idle_done"}, 64'(sel ? done3 : done8), 64'd0);
   endtask

   initial begin
      int last_done;
      int n_done;
      rst = 1'b1; start8 = 1'b0; start3 = 1'b0;
      a8 = '0; b8 = '0; a3 = '0; b3 = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst.busy8", 64'(busy8), 64'd0);
      check_eq("rst.done8", 64'(done8), 64'd0);
      check_eq("rst.res8",  64'(result(1'b0)), 64'd0);
      check_eq("rst.busy3", 64'(busy3), 64'd0);
      check_eq("rst.res3",  64'(result(1'b1)), 64'd0);
      @(negedge clk); rst = 1'b0;

      run_op(1'b0, 8'h0F, 8'h01, 1'b0, "d0f01");
      run_op(1'b0, 8'hFF, 8'h01, 1'b0, "dff01");
      run_op(1'b0, 8'h00, 8'h00, 1'b0, "d0000");
      run_op(1'b0, 8'h55, 8'hAA, 1'b1, "dignore");
      run_op(1'b1, 8'h07, 8'h07, 1'b0, "d3max");

      // reset mid-RUN at edge 4
      @(negedge clk); a8 = 8'hF0; b8 = 8'h0F; start8 = 1'b1;
      @(posedge clk); #1; start8 = 1'b0;
      repeat (3) @(posedge clk);
      @(posedge clk); rst = 1'b1; #1;
      check_eq("mrst.busy", 64'(busy8), 64'd0);
      check_eq("mrst.done", 64'(done8), 64'd0);
      check_eq("mrst.res",  64'(result(1'b0)), 64'd0);
      @(negedge clk); rst = 1'b0;
      run_op(1'b0, 8'h80, 8'h80, 1'b0, "d8080");

      // start held high: restart every WIDTH+2 cycles
      @(negedge clk); a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
      last_done = -1;
      n_done    = 0;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk); #1;
         if (done8) begin
            check_eq("hold.res", 64'(result(1'b0)), 64'h46);
            if (last_done >= 0) check_eq("hold.period", 64'(n - last_done), 64'd10);
            last_done = n;
            n_done++;
         end
      end
      start8 = 1'b0;
      check_eq("hold.count", 64'(n_done), 64'd3);
      for (int n = 0; n < 20 && busy8; n++) begin
         @(posedge clk); #1;
      end
      check_eq("hold.drain", 64'(busy8), 64'd0);

      for (int i = 0; i < 1000; i++) begin
         run_op(1'b0, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 7) == 0), "rnd8");
         run_op(1'b1, 8'($urandom), 8'($urandom), 1'b0, "rnd3");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
